dmem_responder: RTL and testbench

Data-memory responder for the CPU's load/store port. It accepts one request at a time over a valid/ready handshake and performs byte, halfword or word reads and writes on an internal word-organised RAM. It inserts a configurable number of wait states and returns the result over a second valid/ready handshake. It sits on the memory side of the data-memory interface, so the core can be moved from an ideal combinational RAM to a realistic multi-cycle memory.

---
 rtl/dmem_responder.sv | 160 ++++++++++++++++
 tb/tb_dmem_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, byte/half/word access to a word RAM with bounded wait states.
// Latency: response valid LATENCY+1 cycles after accept; registered outputs.
// Backpressure: response held until rsp_ready; req_ready low from accept to response completion.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic          commit;
    logic          access_err;
    logic [31:0]   ram_word;
    logic [31:0]   load_data;
    logic [31:0]   store_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    assign lane     = addr_q[1:0];
    assign idx      = addr_q[AW+1:2];
    assign commit   = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign ram_word = mem[idx];

    assign access_err = (size_q == 2'b11)
                     || (size_q == 2'b01 && lane[0])
                     || (size_q == 2'b10 && lane != 2'b00)
                     || ({1'b0, addr_q} >= ADDR_LIMIT);

    // Load extraction and store merge both work on the currently addressed word.
    always_comb begin
        ld_byte    = ram_word[{lane, 3'b000} +: 8];
        ld_half    = lane[1] ? ram_word[31:16] : ram_word[15:0];
        load_data  = ram_word;
        store_word = ram_word;
        case (size_q)
            2'b00: begin
                load_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
                store_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_data = {{16{signed_q & ld_half[15]}}, ld_half};
                store_word[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                load_data  = ram_word;
                store_word = wdata_q;
            end
        endcase
    end

    // RAM is deliberately outside reset; a reset edge at commit suppresses the write.
    always_ff @(posedge clock) begin
        if (reset && commit && wen_q && !access_err) begin
            mem[idx] <= store_word;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            wen_q    <= 1'b0;
            addr_q   <= 32'd0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wen_d    = req_wen;
                    addr_d   = req_addr;
                    size_d   = req_size;
                    signed_d = req_signed;
                    wdata_d  = req_wdata;
                    cnt_d    = 4'(LATENCY);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    err_d   = access_err;
                    rdata_d = (access_err || wen_q) ? 32'd0 : load_data;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: directed scenarios plus randomized traffic against a memory model.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        time         t_acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [DEPTH];
    int          compared   = 0;
    int          mismatched = 0;
    bit          hold_rdy   = 1'b0;
    bit          rand_rdy   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
        end
    endtask

    // Reference: byte-addressed memory semantics expressed with masks and shifts.
    function automatic void model(input bit wen, input logic [31:0] addr, input logic [1:0] size,
                                  input bit sgn, input logic [31:0] wdata,
                                  output logic [31:0] rd, output logic err);
        int unsigned off;
        int unsigned w;
        logic [31:0] mask;
        logic [31:0] v;
        off = addr % 4;
        err = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
              (size == 2'd2 && off != 0) || (addr >= 32'(4 * DEPTH));
        rd = 32'd0;
        if (err) return;
        w = addr / 4;
        if (size == 2'd0)      mask = 32'h0000_00ff << (8 * off);
        else if (size == 2'd1) mask = 32'h0000_ffff << (8 * off);
        else                   mask = 32'hffff_ffff;
        if (wen) begin
            ref_mem[w] = (ref_mem[w] & ~mask) | ((wdata << (8 * off)) & mask);
        end else begin
            v = (ref_mem[w] & mask) >> (8 * off);
            if (sgn && size == 2'd0 && v >= 32'h80)   v = v | 32'hffff_ff00;
            if (sgn && size == 2'd1 && v >= 32'h8000) v = v | 32'hffff_0000;
            rd = v;
        end
    endfunction

    // Drives rsp_ready just after each rising edge so the monitor sees a settled value.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (hold_rdy)      rsp_ready = 1'b0;
            else if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
            else               rsp_ready = 1'b1;
        end
    end

    // Monitor: checks latency, hold-stability under backpressure, and payload against the queue.
    initial begin
        bit          seen = 1'b0;
        time         rise_t = 0;
        logic [31:0] prev_rd = '0;
        logic        prev_err = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                seen = 1'b0;
            end else if (rsp_valid) begin
                if (!seen) begin
                    seen   = 1'b1;
                    rise_t = $time;
                end else begin
                    check("hold_rdata", rsp_rdata, prev_rd);
                    check("hold_err", 32'(rsp_err), 32'(prev_err));
                end
                prev_rd  = rsp_rdata;
                prev_err = rsp_err;
                if (rsp_ready) begin
                    seen = 1'b0;
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0d want no response", rsp_rdata, rsp_err);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        check("rsp_latency", 32'(rise_t - e.t_acc), 32'((LAT + 1) * 10 + 5));
                    end
                end
            end
        end
    end

    task automatic send(input bit wen, input logic [31:0] addr, input logic [1:0] size,
                        input bit sgn, input logic [31:0] wdata, input bit track);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            compared++;
            mismatched++;
            $display("FAIL req_ready_timeout: got 0 want 1");
            return;
        end
        req_wen    = wen;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(posedge clock);
        if (track) begin
            e.t_acc = $time;
            model(wen, addr, size, sgn, wdata, e.rdata, e.err);
            exp_q.push_back(e);
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0 || !req_ready) begin
            compared++;
            mismatched++;
            $display("FAIL idle_timeout: got %0d pending want 0", exp_q.size());
        end
    endtask

    initial begin
        logic [31:0] a;
        int          n;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = '0;
        req_size   = '0;
        req_signed = 1'b0;
        req_wdata  = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;

        // Word store/load round trip.
        send(1, 32'h80, 2'd2, 0, 32'hffff_ffff, 1);
        send(0, 32'h80, 2'd2, 0, 32'h0, 1);
        wait_idle();

        // Sub-word loads.
        send(1, 32'h80, 2'd2, 0, 32'h1234_5680, 1);
        send(0, 32'h80, 2'd0, 1, 32'h0, 1);
        send(0, 32'h80, 2'd0, 0, 32'h0, 1);
        send(0, 32'h82, 2'd1, 1, 32'h0, 1);
        send(0, 32'h83, 2'd0, 1, 32'h0, 1);
        // Byte-enable stores.
        send(1, 32'h100, 2'd2, 0, 32'h8765_4321, 1);
        send(1, 32'h102, 2'd1, 0, 32'h0000_beef, 1);
        send(0, 32'h100, 2'd2, 0, 32'h0, 1);
        send(0, 32'h102, 2'd1, 1, 32'h0, 1);
        // Errors, including an out-of-range store that must not alias onto word 0.
        send(0, 32'h82, 2'd2, 0, 32'h0, 1);
        send(1, 32'h0, 2'd2, 0, 32'h1122_3344, 1);
        send(1, 32'(4 * DEPTH), 2'd0, 0, 32'h0000_00aa, 1);
        send(0, 32'h0, 2'd2, 0, 32'h0, 1);
        send(0, 32'h80, 2'd3, 0, 32'h0, 1);
        send(0, 32'h81, 2'd1, 0, 32'h0, 1);
        wait_idle();

        // Backpressure: response held five cycles while a stray request is offered.
        hold_rdy = 1'b1;
        @(posedge clock);
        send(0, 32'h100, 2'd2, 0, 32'h0, 1);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
            req_wen   = 1'b1;
            req_addr  = 32'h100;
            req_size  = 2'd2;
            req_wdata = 32'hdead_dead;
            req_valid = (k == 1);
            @(negedge clock);
        end
        req_valid = 1'b0;
        hold_rdy  = 1'b0;
        wait_idle();
        repeat (6) @(negedge clock);
        check("bp_no_extra_rsp", 32'(rsp_valid), 32'd0);
        send(0, 32'h100, 2'd2, 0, 32'h0, 1);
        wait_idle();

        // Reset while the store is still waiting: it must not commit.
        send(1, 32'h80, 2'd2, 0, 32'hffff_ffff, 1);
        wait_idle();
        send(1, 32'h80, 2'd2, 0, 32'hdead_beef, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_req_ready", 32'(req_ready), 32'd1);
        reset = 1'b1;
        send(0, 32'h80, 2'd2, 0, 32'h0, 1);
        wait_idle();

        // Randomized traffic with random response backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) a = 32'(4 * DEPTH) + $urandom_range(0, 15);
            else                           a = 32'h200 + $urandom_range(0, 63);
            send($urandom_range(0, 1), a, 2'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom, 1);
        end
        wait_idle();
        rand_rdy = 1'b0;
        for (int i = 0; i < 16; i++) send(0, 32'h200 + 32'(4 * i), 2'd2, 0, 32'h0, 1);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
